// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC accumulating output register.
// Contents: state_e (accumulator FSM states), default IN_W/ACC_W/CNT_W values.
package mac_pkg;

  localparam int unsigned DefInW  = 20;
  localparam int unsigned DefAccW = 32;
  localparam int unsigned DefCntW = 8;

  // StIdle: no partial sum, StAcc: partial sum held, StHold: result presented
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StHold = 2'd2
  } state_e;

endpackage

// File: rtl/mac_acc_reg_if.sv
// Product-in / result-out bus of mac_acc_reg.
// Input side : vbit_i, last_i, data_i (signed product), rdy_o (block can accept).
// Output side: data_o (result), vbit_o, rdy_i (downstream ready), cnt_o, ovf_o.
// master = producer/consumer side, slave = the accumulator.
interface mac_acc_reg_if #(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 8
);
  logic             vbit_i;
  logic             last_i;
  logic [IN_W-1:0]  data_i;
  logic             rdy_o;
  logic [ACC_W-1:0] data_o;
  logic             vbit_o;
  logic             rdy_i;
  logic [CNT_W-1:0] cnt_o;
  logic             ovf_o;

  modport master (
    output vbit_i, last_i, data_i, rdy_i,
    input  rdy_o, data_o, vbit_o, cnt_o, ovf_o
  );

  modport slave (
    input  vbit_i, last_i, data_i, rdy_i,
    output rdy_o, data_o, vbit_o, cnt_o, ovf_o
  );
endinterface

// File: rtl/mac_acc_add.sv
// Combinational accumulate step: sign-extends a product to ACC_W, adds it to the
// running sum and flags signed overflow.
// Ports: i_acc (running sum), i_data (signed product), o_sum (new sum), o_ovf (overflow).
// Optional MAC_SAT_EN: clamp overflowing sums to the most positive/negative value;
// otherwise the sum wraps. o_ovf is reported in both cases.
module mac_acc_add #(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned ACC_W = 32
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [IN_W-1:0]  i_data,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_raw;

  assign w_ext = ACC_W'($signed(i_data));
  assign w_raw = i_acc + w_ext;

  // Overflow only when both operands share a sign and the result does not
  assign o_ovf = (i_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_raw[ACC_W-1] != i_acc[ACC_W-1]);

`ifdef MAC_SAT_EN
  always_comb begin
    o_sum = w_raw;
    if (o_ovf) begin
      o_sum = i_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/mac_acc_reg.sv
// Accumulating output register at the tail of the MAC pipeline. Sums valid signed
// products until last_i, then presents the result with a valid/ready handshake.
// Ports: clk, rstn (async active-low), clean (sync flush), en (input stage enable),
//        bus (mac_acc_reg_if.slave: vbit_i/last_i/data_i/rdy_o in,
//             data_o/vbit_o/rdy_i/cnt_o/ovf_o out).
// Optional MAC_SAT_EN (in mac_acc_add): saturating instead of wrapping accumulation.
module mac_acc_reg
  import mac_pkg::*;
#(
  parameter int unsigned IN_W  = DefInW,
  parameter int unsigned ACC_W = DefAccW,
  parameter int unsigned CNT_W = DefCntW
) (
  input logic          clk,
  input logic          rstn,
  input logic          clean,
  input logic          en,
  mac_acc_reg_if.slave bus
);

  state_e           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ovf, w_ovf_nxt;

  logic             w_rdy;
  logic             w_accept;
  logic [ACC_W-1:0] w_add_a;
  logic [ACC_W-1:0] w_sum;
  logic             w_add_ovf;

  assign w_rdy    = (r_state != StHold);
  assign w_accept = en & bus.vbit_i & w_rdy;

  // First term of a sum adds onto zero, so it is a plain sign-extended load
  assign w_add_a = (r_state == StIdle) ? '0 : r_acc;

  mac_acc_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_add (
    .i_acc  (w_add_a),
    .i_data (bus.data_i),
    .o_sum  (w_sum),
    .o_ovf  (w_add_ovf)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    if (clean) begin
      w_state_nxt = StIdle;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StAcc: begin
          if (w_accept) begin
            w_acc_nxt = w_sum;
            if (r_state == StIdle) begin
              w_cnt_nxt = CNT_W'(1);
            end else if (!(&r_cnt)) begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            w_ovf_nxt   = ((r_state == StAcc) & r_ovf) | w_add_ovf;
            w_state_nxt = bus.last_i ? StHold : StAcc;
          end
        end
        StHold: begin
          // Accumulator is left as-is; the next accept in StIdle overwrites it
          if (bus.rdy_i) w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign bus.rdy_o  = w_rdy;
  assign bus.vbit_o = (r_state == StHold);
  assign bus.data_o = r_acc;
  assign bus.cnt_o  = r_cnt;
  assign bus.ovf_o  = r_ovf;

endmodule

// File: tb/tb_mac_acc_reg.sv
// Bench for mac_acc_reg: two instances share one stimulus stream.
//   dut_a: IN_W=20, ACC_W=32, CNT_W=8 (wide accumulator, no overflow here)
//   dut_b: IN_W=20, ACC_W=20, CNT_W=2 (overflow and counter saturation)
// Table of directed vectors plus hand-written async reset sequences.
module tb_mac_acc_reg;

  logic clk = 1'b0;
  logic rstn;
  logic clean;
  logic en;

  always #5 clk = ~clk;

  mac_acc_reg_if #(.IN_W(20), .ACC_W(32), .CNT_W(8)) if_a ();
  mac_acc_reg_if #(.IN_W(20), .ACC_W(20), .CNT_W(2)) if_b ();

  assign if_b.vbit_i = if_a.vbit_i;
  assign if_b.last_i = if_a.last_i;
  assign if_b.data_i = if_a.data_i;
  assign if_b.rdy_i  = if_a.rdy_i;

  mac_acc_reg #(.IN_W(20), .ACC_W(32), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rstn  (rstn),
    .clean (clean),
    .en    (en),
    .bus   (if_a.slave)
  );

  mac_acc_reg #(.IN_W(20), .ACC_W(20), .CNT_W(2)) dut_b (
    .clk   (clk),
    .rstn  (rstn),
    .clean (clean),
    .en    (en),
    .bus   (if_b.slave)
  );

`ifdef MAC_SAT_EN
  localparam logic [19:0] OvfPosB = 20'h7FFFF;
  localparam logic [19:0] OvfNegB = 20'h80000;
`else
  localparam logic [19:0] OvfPosB = 20'h80005;
  localparam logic [19:0] OvfNegB = 20'h7FFFF;
`endif

  typedef struct {
    bit          cln, en, vb, lst, rdy;
    logic [19:0] d;
    bit          e_rdy, e_vb;
    logic [31:0] e_da;
    logic [19:0] e_db;
    int          e_ca, e_oa, e_cb, e_ob;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic addv(input bit cln, input bit e, input bit vb, input bit lst,
                      input logic [19:0] d, input bit rdy, input bit er, input bit ev,
                      input logic [31:0] eda, input logic [19:0] edb,
                      input int eca, input int eoa, input int ecb, input int eob);
    vec_t v;
    v.cln = cln; v.en = e; v.vb = vb; v.lst = lst; v.d = d; v.rdy = rdy;
    v.e_rdy = er; v.e_vb = ev; v.e_da = eda; v.e_db = edb;
    v.e_ca = eca; v.e_oa = eoa; v.e_cb = ecb; v.e_ob = eob;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit cln, input bit e, input bit vb, input bit lst,
                       input logic [19:0] d, input bit rdy);
    clean       = cln;
    en          = e;
    if_a.vbit_i = vb;
    if_a.last_i = lst;
    if_a.data_i = d;
    if_a.rdy_i  = rdy;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " rdy_a"},  32'(if_a.rdy_o), 32'd1);
    chk({tag, " vbit_a"}, 32'(if_a.vbit_o), 32'd0);
    chk({tag, " data_a"}, if_a.data_o, 32'd0);
    chk({tag, " cnt_a"},  32'(if_a.cnt_o), 32'd0);
    chk({tag, " ovf_a"},  32'(if_a.ovf_o), 32'd0);
    chk({tag, " vbit_b"}, 32'(if_b.vbit_o), 32'd0);
    chk({tag, " data_b"}, 32'(if_b.data_o), 32'd0);
    chk({tag, " cnt_b"},  32'(if_b.cnt_o), 32'd0);
    chk({tag, " ovf_b"},  32'(if_b.ovf_o), 32'd0);
  endtask

  initial begin
    // cln en vb lst data rdy | rdy vb dataA dataB cntA ovfA cntB ovfB
    // Basic sum 5, -3, 10
    addv(0,1,1,0,20'd5,    1, 1,0,32'd0,20'd0, 1,0,1,0);
    addv(0,1,1,0,20'hFFFFD,1, 1,0,32'd0,20'd0, 2,0,2,0);
    addv(0,1,1,1,20'd10,   1, 0,1,32'd12,20'd12, 3,0,3,0);
    addv(0,1,0,0,20'd0,    1, 1,0,32'd0,20'd0, 3,0,3,0);
    // Backpressure: single term 7, rdy_i low, extra inputs ignored
    addv(0,1,1,1,20'd7,    0, 0,1,32'd7,20'd7, 1,0,1,0);
    for (int k = 0; k < 4; k++) addv(0,1,1,0,20'd100,0, 0,1,32'd7,20'd7, 1,0,1,0);
    addv(0,1,1,1,20'd100,  1, 1,0,32'd0,20'd0, 1,0,1,0);
    // Stall mid-sum with en low; en low does not stall the transfer
    addv(0,1,1,0,20'hFFFF8,1, 1,0,32'd0,20'd0, 1,0,1,0);
    for (int k = 0; k < 3; k++) addv(0,0,1,0,20'd1000,1, 1,0,32'd0,20'd0, 1,0,1,0);
    addv(0,1,1,1,20'd3,    1, 0,1,32'hFFFFFFFB,20'hFFFFB, 2,0,2,0);
    addv(0,0,0,0,20'd0,    1, 1,0,32'd0,20'd0, 2,0,2,0);
    // Positive overflow in B, sticky flag, then a further positive term
    addv(0,1,1,0,20'h7FFFF,1, 1,0,32'd0,20'd0, 1,0,1,0);
    addv(0,1,1,0,20'd1,    1, 1,0,32'd0,20'd0, 2,0,2,1);
    addv(0,1,1,1,20'd5,    1, 0,1,32'h00080005,OvfPosB, 3,0,3,1);
    addv(0,1,0,0,20'd0,    1, 1,0,32'd0,20'd0, 3,0,3,1);
    // Negative overflow in B; new sum clears the flag
    addv(0,1,1,0,20'h80000,1, 1,0,32'd0,20'd0, 1,0,1,0);
    addv(0,1,1,1,20'hFFFFF,1, 0,1,32'hFFF7FFFF,OvfNegB, 2,0,2,1);
    addv(0,1,0,0,20'd0,    1, 1,0,32'd0,20'd0, 2,0,2,1);
    // Flush mid-sum (input same cycle ignored), new sum 4, flush in HOLD
    addv(0,1,1,0,20'd9,    1, 1,0,32'd0,20'd0, 1,0,1,0);
    addv(0,1,1,0,20'd6,    1, 1,0,32'd0,20'd0, 2,0,2,0);
    addv(1,1,1,1,20'd50,   1, 1,0,32'd0,20'd0, 0,0,0,0);
    addv(0,1,1,1,20'd4,    0, 0,1,32'd4,20'd4, 1,0,1,0);
    addv(1,1,0,0,20'd0,    0, 1,0,32'd0,20'd0, 0,0,0,0);
    // Five terms of 1: B counter saturates at 3
    addv(0,1,1,0,20'd1,    1, 1,0,32'd0,20'd0, 1,0,1,0);
    addv(0,1,1,0,20'd1,    1, 1,0,32'd0,20'd0, 2,0,2,0);
    addv(0,1,1,0,20'd1,    1, 1,0,32'd0,20'd0, 3,0,3,0);
    addv(0,1,1,0,20'd1,    1, 1,0,32'd0,20'd0, 4,0,3,0);
    addv(0,1,1,1,20'd1,    1, 0,1,32'd5,20'd5, 5,0,3,0);
    addv(0,1,0,0,20'd0,    1, 1,0,32'd0,20'd0, 5,0,3,0);
    // last_i without vbit_i is ignored, in IDLE and in ACC
    addv(0,1,0,1,20'd77,   1, 1,0,32'd0,20'd0, 5,0,3,0);
    addv(0,1,1,0,20'd2,    1, 1,0,32'd0,20'd0, 1,0,1,0);
    addv(0,1,0,1,20'd77,   1, 1,0,32'd0,20'd0, 1,0,1,0);
    addv(0,1,1,1,20'd3,    1, 0,1,32'd5,20'd5, 2,0,2,0);
    addv(0,1,0,0,20'd0,    1, 1,0,32'd0,20'd0, 2,0,2,0);

    rstn = 1'b0;
    drive(0, 0, 0, 0, 20'd0, 0);
    #2;
    chk_reset("reset");
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cln, vecs[i].en, vecs[i].vb, vecs[i].lst, vecs[i].d, vecs[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rdy_a", i),  32'(if_a.rdy_o),  32'(vecs[i].e_rdy));
      chk($sformatf("v%0d rdy_b", i),  32'(if_b.rdy_o),  32'(vecs[i].e_rdy));
      chk($sformatf("v%0d vbit_a", i), 32'(if_a.vbit_o), 32'(vecs[i].e_vb));
      chk($sformatf("v%0d vbit_b", i), 32'(if_b.vbit_o), 32'(vecs[i].e_vb));
      chk($sformatf("v%0d cnt_a", i),  32'(if_a.cnt_o),  32'(vecs[i].e_ca));
      chk($sformatf("v%0d ovf_a", i),  32'(if_a.ovf_o),  32'(vecs[i].e_oa));
      chk($sformatf("v%0d cnt_b", i),  32'(if_b.cnt_o),  32'(vecs[i].e_cb));
      chk($sformatf("v%0d ovf_b", i),  32'(if_b.ovf_o),  32'(vecs[i].e_ob));
      if (vecs[i].e_vb) begin
        chk($sformatf("v%0d data_a", i), if_a.data_o, vecs[i].e_da);
        chk($sformatf("v%0d data_b", i), 32'(if_b.data_o), 32'(vecs[i].e_db));
      end
    end

    // Async reset mid-sum: outputs clear without a clock edge
    drive(0, 1, 1, 0, 20'd3, 1);
    @(posedge clk); #1;
    drive(0, 1, 1, 0, 20'd3, 1);
    @(posedge clk); #1;
    chk("midsum cnt_a", 32'(if_a.cnt_o), 32'd2);
    drive(0, 1, 0, 0, 20'd0, 1);
    #1;
    rstn = 1'b0;
    #1;
    chk_reset("async midsum");
    @(negedge clk);
    rstn = 1'b1;

    // Async reset mid-HOLD
    drive(0, 1, 1, 1, 20'd6, 0);
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 20'd0, 0);
    chk("hold vbit_a", 32'(if_a.vbit_o), 32'd1);
    chk("hold data_a", if_a.data_o, 32'd6);
    #1;
    rstn = 1'b0;
    #1;
    chk_reset("async hold");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post reset vbit_a", 32'(if_a.vbit_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_acc_reg.md
Name: mac_acc_reg

Overview:
Parametrised accumulating output register for the MAC datapath, the successor of the single-stage valid/data pipeline register. It sums a stream of signed products tagged by a valid bit until a last flag arrives, then holds the result behind a valid/ready handshake towards the downstream consumer. It sits at the tail of the MAC pipeline, between the multiplier pipeline registers and the result bus.

Parameters:
IN_W, 20, width of signed input product
ACC_W, 32, width of signed accumulator and result; must be >= IN_W
CNT_W, 8, width of the accumulated-term counter

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
clean  input  1  synchronous flush; highest priority after reset
en  input  1  input stage enable; no input accepted when low
vbit_i  input  1  input product valid
last_i  input  1  current product is final term of the sum; qualified by vbit_i
data_i  input  IN_W  signed product
rdy_o  output  1  block can accept an input term
data_o  output  ACC_W  accumulated result
vbit_o  output  1  result valid
rdy_i  input  1  downstream ready for result
cnt_o  output  CNT_W  number of terms in current/held sum
ovf_o  output  1  sticky signed overflow of current/held sum

Behaviour:
- Reset (rstn low, asynchronous): state IDLE, accumulator 0, cnt_o 0, ovf_o 0, vbit_o 0; data_o 0.
- States: IDLE (no partial sum), ACC (partial sum held), HOLD (result presented).
- rdy_o = 1 in IDLE and ACC, 0 in HOLD; depends on state only, not on en or rdy_i.
- Input accept = en & vbit_i & rdy_o. No accept -> accumulator, cnt_o and state unchanged.
- Accept in IDLE: acc <= sign-extend(data_i); cnt_o <= 1; ovf_o <= 0; next state HOLD if last_i, else ACC.
- Accept in ACC: acc <= acc + sign-extend(data_i); cnt_o <= cnt_o+1, saturating at 2^CNT_W-1; ovf_o |= signed overflow of the add; next state HOLD if last_i, else ACC.
- Arithmetic: two's complement, result truncated to ACC_W (wrap) unless MAC_SAT_EN.
- HOLD: vbit_o = 1 and data_o = acc, both registered (valid the cycle after the last_i accept). Data stable while vbit_o=1 and rdy_i=0.
- HOLD & rdy_i: transfer complete; next cycle state IDLE, vbit_o 0. The accumulator keeps its value until the next accept (data_o is don't-care while vbit_o=0). No input is accepted in the transfer cycle.
- Output handshake is independent of en: en=0 does not stall a HOLD transfer.
- clean=1: state IDLE, acc 0, cnt_o 0, ovf_o 0, vbit_o 0 next cycle. Any held or partial result is discarded; an input or transfer in the same cycle is ignored.
- Reset mid-sum or mid-HOLD: partial or held result is lost, outputs return to reset values immediately.
- last_i without vbit_i is ignored.

Optional Feature:
MAC_SAT_EN: when defined, an overflowing add clamps acc to the most positive (2^(ACC_W-1)-1) or most negative (-2^(ACC_W-1)) value and stays there on further same-sign overflow; ovf_o is still set. Undefined: two's complement wrap, ovf_o still set.

Decomposition:
- Package mac_pkg: state enum (IDLE/ACC/HOLD) and default width constants IN_W/ACC_W/CNT_W.
- One sub-module mac_acc_add: combinational sign-extend + add + overflow detect + optional saturation, parametrised by IN_W/ACC_W.
- The FSM and registers stay in mac_acc_reg.

Test Plan:
- Basic sum: IN_W=20, ACC_W=32. Inputs 5, -3, 10 (last on 10), en=1, rdy_i=1 -> vbit_o pulses 1 cycle with data_o=12, cnt_o=3, ovf_o=0.
- Backpressure: single term 7 with last, rdy_i=0 for 4 cycles -> vbit_o=1 and data_o=7 stable, rdy_o=0, further vbit_i ignored; rdy_i=1 -> IDLE next cycle.
- Stall: en=0 with vbit_i=1 for 3 cycles mid-sum -> acc and cnt_o unchanged; en=1 resumes and the sum is correct.
- Overflow: ACC_W=20, inputs 0x7FFFF then 1 (last) -> ovf_o=1. Without MAC_SAT_EN data_o=0x80000; with MAC_SAT_EN data_o=0x7FFFF.
- Flush: clean asserted after 2 terms, then new sum 4 (last) -> data_o=4, cnt_o=1, ovf_o=0. Clean asserted in HOLD -> vbit_o drops next cycle.
- Counter saturation: CNT_W=2, 5 terms of 1 -> cnt_o=3, data_o=5; async reset mid-sum -> all outputs 0 immediately.
